// File: rtl/q_column3_norm.sv
//------------------------------------------------------------------------------
// q_column3_norm : iterative Euclidean norm (R33) and unit column (Q_col3) of
// the Gram-Schmidt column-3 vector. Optional macro: QCOL3_ROUND_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module q_column3_norm #(
    parameter int W    = 16,
    parameter int FRAC = 12
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable,
    input  logic           ready_in,
    input  logic           accept_in,
    output logic           accept_out,
    output logic           ready_out,
    input  logic [4*W-1:0] Q_col3_pre,
    output logic [4*W-1:0] Q_col3,
    output logic [W-1:0]   R33
);

    localparam int c_ACC_W  = 2*W + 2;
    localparam int c_ROOT_W = c_ACC_W / 2;
`ifdef QCOL3_ROUND_EN
    localparam int c_DIV_BITS = FRAC + 2;
`else
    localparam int c_DIV_BITS = FRAC + 1;
`endif
    localparam int c_DIV_W = c_ROOT_W + c_DIV_BITS;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SUMSQ = 3'd1;
    localparam logic [2:0] c_SQRT  = 3'd2;
    localparam logic [2:0] c_DIV   = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [c_DIV_BITS:0]   c_ONE_Q   = (c_DIV_BITS+1)'(1 << FRAC);
    localparam logic [c_ROOT_W-1:0]   c_R33_MAX = c_ROOT_W'((1 << (W-1)) - 1);

    function automatic logic [W-1:0] f_elem(input logic [4*W-1:0] v, input logic [1:0] k);
        return v[(3 - int'(k))*W +: W];
    endfunction

    function automatic logic [W-1:0] f_abs(input logic [W-1:0] e);
        return e[W-1] ? (~e + 1'b1) : e;
    endfunction

    logic [2:0]            r_state;
    logic [4:0]            r_cnt;
    logic [1:0]            r_elem;
    logic [4*W-1:0]        r_vec;
    logic [c_ACC_W-1:0]    r_acc;
    logic [c_ROOT_W+2:0]   r_srem;
    logic [c_ROOT_W-1:0]   r_root;
    logic [c_DIV_W-1:0]    r_rem;
    logic [c_DIV_W-1:0]    r_div;
    logic [c_DIV_BITS-2:0] r_quo;
    logic [4*W-1:0]        r_q_out;
    logic [W-1:0]          r_r33;
    logic                  r_ready;
    logic                  r_accept;

    logic [1:0]            w_idx;
    logic signed [W-1:0]   w_e;
    logic signed [2*W-1:0] w_sq;
    logic [c_ROOT_W+2:0]   w_srem;
    logic [c_ROOT_W+2:0]   w_trial;
    logic                  w_sge;
    logic [c_ROOT_W+2:0]   w_srem_n;
    logic [c_ROOT_W-1:0]   w_root_n;
    logic                  w_dge;
    logic [c_DIV_W-1:0]    w_rem_n;
    logic [c_DIV_BITS-1:0] w_quo_n;
    logic [c_DIV_BITS:0]   w_mag_raw;
    logic [W-1:0]          w_mag;
    logic [W-1:0]          w_qval;
    logic [1:0]            w_ld_idx;
    logic [c_ROOT_W-1:0]   w_ld_root;
    logic [c_DIV_W-1:0]    w_ld_rem;
    logic [c_DIV_W-1:0]    w_ld_div;
    logic [W-1:0]          w_r33;

    assign w_idx = (r_state == c_SUMSQ) ? r_cnt[1:0] : r_elem;
    assign w_e   = $signed(f_elem(r_vec, w_idx));
    assign w_sq  = w_e * w_e;

    // Square root: bring down two radicand bits per cycle from the top of r_acc
    assign w_srem   = (r_srem << 2) | {{(c_ROOT_W+1){1'b0}}, r_acc[c_ACC_W-1 -: 2]};
    assign w_trial  = {1'b0, r_root, 2'b01};
    assign w_sge    = (w_srem >= w_trial);
    assign w_srem_n = w_sge ? (w_srem - w_trial) : w_srem;
    assign w_root_n = {r_root[c_ROOT_W-2:0], w_sge};

    assign w_dge   = (r_rem >= r_div);
    assign w_rem_n = w_dge ? (r_rem - r_div) : r_rem;
    assign w_quo_n = {r_quo, w_dge};

`ifdef QCOL3_ROUND_EN
    assign w_mag_raw = ({1'b0, w_quo_n} + 1'b1) >> 1;
`else
    assign w_mag_raw = {1'b0, w_quo_n};
`endif
    // A zero root means a zero vector: suppress the all-ones quotient
    assign w_mag  = (r_root == '0) ? '0 :
                    (w_mag_raw > c_ONE_Q) ? W'(c_ONE_Q) : W'(w_mag_raw);
    assign w_qval = w_e[W-1] ? (~w_mag + 1'b1) : w_mag;

    assign w_ld_idx  = (r_state == c_SQRT) ? 2'd0 : (r_elem + 2'd1);
    assign w_ld_root = (r_state == c_SQRT) ? w_root_n : r_root;
    assign w_ld_rem  = c_DIV_W'(f_abs(f_elem(r_vec, w_ld_idx))) << (c_DIV_BITS-1);
    assign w_ld_div  = c_DIV_W'(w_ld_root) << (c_DIV_BITS-1);
    assign w_r33     = (r_root > c_R33_MAX) ? W'(c_R33_MAX) : r_root[W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_elem   <= '0;
            r_vec    <= '0;
            r_acc    <= '0;
            r_srem   <= '0;
            r_root   <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_quo    <= '0;
            r_q_out  <= '0;
            r_r33    <= '0;
            r_ready  <= 1'b0;
            r_accept <= 1'b1;
        end else if (enable) begin
            case (r_state)
                c_IDLE: begin
                    if (ready_in) begin
                        r_vec    <= Q_col3_pre;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_accept <= 1'b0;
                        r_state  <= c_SUMSQ;
                    end
                end
                c_SUMSQ: begin
                    r_acc <= r_acc + c_ACC_W'($unsigned(w_sq));
                    if (r_cnt == 5'd3) begin
                        r_cnt   <= '0;
                        r_srem  <= '0;
                        r_root  <= '0;
                        r_state <= c_SQRT;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                c_SQRT: begin
                    r_acc  <= r_acc << 2;
                    r_srem <= w_srem_n;
                    r_root <= w_root_n;
                    if (r_cnt == 5'(c_ROOT_W-1)) begin
                        r_cnt   <= '0;
                        r_elem  <= '0;
                        r_rem   <= w_ld_rem;
                        r_div   <= w_ld_div;
                        r_quo   <= '0;
                        r_state <= c_DIV;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                c_DIV: begin
                    r_rem <= w_rem_n;
                    r_div <= r_div >> 1;
                    r_quo <= w_quo_n[c_DIV_BITS-2:0];
                    if (r_cnt == 5'(c_DIV_BITS-1)) begin
                        r_q_out[(3 - int'(r_elem))*W +: W] <= w_qval;
                        r_cnt <= '0;
                        r_quo <= '0;
                        if (r_elem == 2'd3) begin
                            r_r33   <= w_r33;
                            r_ready <= 1'b1;
                            r_state <= c_DONE;
                        end else begin
                            r_elem <= r_elem + 2'd1;
                            r_rem  <= w_ld_rem;
                            r_div  <= w_ld_div;
                        end
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                c_DONE: begin
                    if (accept_in) begin
                        r_ready  <= 1'b0;
                        r_accept <= 1'b1;
                        r_state  <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign accept_out = r_accept;
    assign ready_out  = r_ready;
    assign Q_col3     = r_q_out;
    assign R33        = r_r33;

endmodule

`default_nettype wire

// File: tb/tb_q_column3_norm.sv
//------------------------------------------------------------------------------
// tb_q_column3_norm : randomized self-checking bench for q_column3_norm against
// an arithmetic reference model (norm by real sqrt, quotient by integer divide).
//------------------------------------------------------------------------------
`default_nettype none

module tb_q_column3_norm;

`ifdef QCOL3_ROUND_EN
    localparam int LAT = 77;
`else
    localparam int LAT = 73;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        ready_in;
    logic        accept_in;
    logic        accept_out;
    logic        ready_out;
    logic [63:0] Q_col3_pre;
    logic [63:0] Q_col3;
    logic [15:0] R33;

    int n_cmp = 0;
    int n_bad = 0;

    q_column3_norm #(.W(16), .FRAC(12)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .ready_in   (ready_in),
        .accept_in  (accept_in),
        .accept_out (accept_out),
        .ready_out  (ready_out),
        .Q_col3_pre (Q_col3_pre),
        .Q_col3     (Q_col3),
        .R33        (R33)
    );

    always #5 clk = ~clk;

    // Reference: {R33, Q_col3}
    function automatic logic [79:0] model(input logic [63:0] v);
        longint e [4];
        longint sum, r, mag, qm;
        logic [63:0] q;
        logic [15:0] rr;
        sum = 0;
        q   = '0;
        for (int k = 0; k < 4; k++) begin
            e[k] = longint'($signed(v[63-16*k -: 16]));
            sum += e[k] * e[k];
        end
        r = longint'($sqrt(real'(sum)));
        while (r * r > sum) r--;
        while ((r + 1) * (r + 1) <= sum) r++;
        rr = (r > 32767) ? 16'h7FFF : 16'(r);
        for (int k = 0; k < 4; k++) begin
            mag = (e[k] < 0) ? -e[k] : e[k];
            if (r == 0) qm = 0;
            else begin
`ifdef QCOL3_ROUND_EN
                qm = (((mag * 8192) / r) + 1) / 2;
                if (qm > 4096) qm = 4096;
`else
                qm = (mag * 4096) / r;
`endif
            end
            q[63-16*k -: 16] = 16'((e[k] < 0) ? -qm : qm);
        end
        return {rr, q};
    endfunction

    // Drives one transaction; returns latency, results and handshake observations
    task automatic run_vec(input logic [63:0] v, input int stall_at, input int stall_len,
                           input int bp, input bit noise,
                           output int lat, output logic [63:0] q, output logic [15:0] r,
                           output bit acc_low, output bit stable, output bit post_ok);
        int w;
        w = 0;
        while (accept_out !== 1'b1 && w < 300) begin @(negedge clk); w++; end
        Q_col3_pre = v;
        ready_in   = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        acc_low  = (accept_out === 1'b0);
        lat = 0;
        while (ready_out !== 1'b1 && lat < 400) begin
            if (noise) begin
                ready_in   = 1'b1;
                Q_col3_pre = {$urandom, $urandom};
            end
            if (lat == stall_at) enable = 1'b0;
            if (lat == stall_at + stall_len) enable = 1'b1;
            @(negedge clk);
            lat++;
        end
        ready_in = 1'b0;
        enable   = 1'b1;
        q = Q_col3;
        r = R33;
        stable = 1'b1;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (Q_col3 !== q || R33 !== r || ready_out !== 1'b1) stable = 1'b0;
        end
        accept_in = 1'b1;
        @(negedge clk);
        accept_in = 1'b0;
        post_ok = (ready_out === 1'b0 && accept_out === 1'b1);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (accept_out !== 1'b1) begin n_bad++; $display("FAIL reset_accept got %b want 1", accept_out); end
        n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", ready_out); end
        n_cmp++; if (Q_col3 !== 64'h0) begin n_bad++; $display("FAIL reset_q got %h want 0", Q_col3); end
        n_cmp++; if (R33 !== 16'h0) begin n_bad++; $display("FAIL reset_r33 got %h want 0", R33); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (accept_out !== 1'b1 || ready_out !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle got acc=%b rdy=%b want 1/0", accept_out, ready_out);
        end
    endtask

    task automatic test_basic;
        int lat; logic [63:0] q; logic [15:0] r; bit al, st, po; logic [79:0] m;
        m = model(64'h0CCC_0999_0666_0999);
        accept_in = 1'b1;
        run_vec(64'h0CCC_0999_0666_0999, -1, 0, 0, 1'b0, lat, q, r, al, st, po);
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
        n_cmp++; if (r !== 16'h13B8) begin n_bad++; $display("FAIL basic_r33 got %h want 13b8", r); end
        n_cmp++; if (q !== m[63:0]) begin n_bad++; $display("FAIL basic_q got %h want %h", q, m[63:0]); end
        n_cmp++; if (!al) begin n_bad++; $display("FAIL basic_accept_low got 1 want 0 while busy"); end
        n_cmp++; if (!po) begin n_bad++; $display("FAIL basic_post got rdy=%b acc=%b want 0/1", ready_out, accept_out); end
`ifndef QCOL3_ROUND_EN
        n_cmp++; if (q !== 64'h0A62_07C9_0531_07C9) begin n_bad++; $display("FAIL basic_q_const got %h want 0a6207c9053107c9", q); end
`endif
    endtask

    task automatic test_back_to_back;
        int lat; logic [63:0] q; logic [15:0] r; bit al, st, po;
        run_vec(64'h1000_0000_0000_0000, -1, 0, 0, 1'b0, lat, q, r, al, st, po);
        n_cmp++; if (r !== 16'h1000) begin n_bad++; $display("FAIL b2b_r33_a got %h want 1000", r); end
        n_cmp++; if (q !== 64'h1000_0000_0000_0000) begin n_bad++; $display("FAIL b2b_q_a got %h want 1000000000000000", q); end
        run_vec(64'hF000_0000_0000_0000, -1, 0, 0, 1'b0, lat, q, r, al, st, po);
        n_cmp++; if (r !== 16'h1000) begin n_bad++; $display("FAIL b2b_r33_b got %h want 1000", r); end
        n_cmp++; if (q !== 64'hF000_0000_0000_0000) begin n_bad++; $display("FAIL b2b_q_b got %h want f000000000000000", q); end
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_zero;
        int lat; logic [63:0] q; logic [15:0] r; bit al, st, po;
        run_vec(64'h0, -1, 0, 0, 1'b0, lat, q, r, al, st, po);
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL zero_latency got %0d want %0d", lat, LAT); end
        n_cmp++; if (r !== 16'h0) begin n_bad++; $display("FAIL zero_r33 got %h want 0", r); end
        n_cmp++; if (q !== 64'h0) begin n_bad++; $display("FAIL zero_q got %h want 0", q); end
    endtask

    task automatic test_saturate;
        int lat; logic [63:0] q; logic [15:0] r; bit al, st, po;
        run_vec(64'h7FFF_7FFF_7FFF_7FFF, -1, 0, 0, 1'b0, lat, q, r, al, st, po);
        n_cmp++; if (r !== 16'h7FFF) begin n_bad++; $display("FAIL sat_r33 got %h want 7fff", r); end
        n_cmp++; if (q !== 64'h0800_0800_0800_0800) begin n_bad++; $display("FAIL sat_q got %h want 0800080008000800", q); end
        run_vec(64'h8000_8000_8000_8000, -1, 0, 0, 1'b0, lat, q, r, al, st, po);
        n_cmp++; if (r !== 16'h7FFF) begin n_bad++; $display("FAIL sat_neg_r33 got %h want 7fff", r); end
        n_cmp++; if (q !== 64'hF800_F800_F800_F800) begin n_bad++; $display("FAIL sat_neg_q got %h want f800f800f800f800", q); end
    endtask

    task automatic test_backpressure_enable;
        int lat; logic [63:0] q; logic [15:0] r; bit al, st, po; logic [63:0] v; logic [79:0] m;
        v = {$urandom, $urandom};
        m = model(v);
        run_vec(v, 6, 10, 20, 1'b0, lat, q, r, al, st, po);
        n_cmp++; if (lat !== LAT + 10) begin n_bad++; $display("FAIL stall_latency got %0d want %0d", lat, LAT + 10); end
        n_cmp++; if (!st) begin n_bad++; $display("FAIL bp_stable got unstable want stable outputs"); end
        n_cmp++; if ({r, q} !== m) begin n_bad++; $display("FAIL stall_result got %h want %h", {r, q}, m); end
        n_cmp++; if (!po) begin n_bad++; $display("FAIL bp_post got rdy=%b acc=%b want 0/1", ready_out, accept_out); end
    endtask

    task automatic test_ignore_busy;
        int lat; logic [63:0] q; logic [15:0] r; bit al, st, po; logic [63:0] v; logic [79:0] m;
        v = {$urandom, $urandom};
        m = model(v);
        run_vec(v, -1, 0, 0, 1'b1, lat, q, r, al, st, po);
        n_cmp++; if ({r, q} !== m) begin n_bad++; $display("FAIL busy_ignore got %h want %h", {r, q}, m); end
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL busy_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_random;
        int lat; logic [63:0] q; logic [15:0] r; bit al, st, po; logic [63:0] v; logic [79:0] m;
        for (int n = 0; n < 24; n++) begin
            v = {$urandom, $urandom};
            // Vary magnitudes so small norms and single dominant elements appear
            if (n % 3 == 1) v = v & 64'h00FF_00FF_00FF_00FF;
            if (n % 3 == 2) v = v & {16'hFFFF, 48'h0000_0000_001F};
            m = model(v);
            run_vec(v, -1, 0, $urandom_range(0, 3), 1'b0, lat, q, r, al, st, po);
            n_cmp++; if ({r, q} !== m) begin n_bad++; $display("FAIL rand_%0d got %h want %h (in %h)", n, {r, q}, m, v); end
            n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL rand_lat_%0d got %0d want %0d", n, lat, LAT); end
        end
    endtask

    task automatic test_reset_mid_div;
        int lat; logic [63:0] q; logic [15:0] r; bit al, st, po; logic [63:0] v; logic [79:0] m;
        Q_col3_pre = 64'h1234_0567_F89A_0BCD;
        ready_in   = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        repeat (40) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (accept_out !== 1'b1 || ready_out !== 1'b0) begin
            n_bad++; $display("FAIL midreset_hs got acc=%b rdy=%b want 1/0", accept_out, ready_out);
        end
        n_cmp++; if (Q_col3 !== 64'h0 || R33 !== 16'h0) begin
            n_bad++; $display("FAIL midreset_out got %h/%h want 0/0", Q_col3, R33);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        v = {$urandom, $urandom};
        m = model(v);
        run_vec(v, -1, 0, 0, 1'b0, lat, q, r, al, st, po);
        n_cmp++; if ({r, q} !== m) begin n_bad++; $display("FAIL midreset_fresh got %h want %h", {r, q}, m); end
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL midreset_lat got %0d want %0d", lat, LAT); end
    endtask

    initial begin
        enable     = 1'b1;
        ready_in   = 1'b0;
        accept_in  = 1'b0;
        Q_col3_pre = '0;
        reset_n    = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        accept_in = 1'b0;
        test_back_to_back();
        test_zero();
        test_saturate();
        test_backpressure_enable();
        test_ignore_busy();
        test_random();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
